sudoku_grid_checker: RTL and testbench

Parametrised successor to the 4x4 game checker. It scans an N x N Sudoku grid (N = BOX*BOX) held in board RAM one row per cycle and checks every row, column and box for duplicates and out-of-range values. It reports a per-category error summary plus `gameValid` and `gameComplete`. It sits between the board RAM read port and the game-control FSM, which starts a check after every move.

---
 rtl/sudoku_pkg.sv | 32 +++
 rtl/sudoku_grid_checker_if.sv | 31 +++
 rtl/sudoku_row_decoder.sv | 41 ++++
 rtl/sudoku_grid_checker.sv | 145 ++++++++++++++
 tb/tb_sudoku_grid_checker.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku grid checker: FSM state encoding,
// default cell width, box numbering and row-word cell extraction.
package sudoku_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        LAST,
        DONE
    } checkStateT;

    localparam int DEFAULT_CELL_W = 4;
    localparam int MAX_ROW_W      = 256;
    localparam int MAX_CELL_W     = 16;

    function automatic int boxIndex(input int r, input int c, input int box);
        return (r / box) * box + c / box;
    endfunction

    // Cell 0 occupies the most-significant field of the row word.
    function automatic logic [MAX_CELL_W-1:0] cellField(
        input logic [MAX_ROW_W-1:0] rowWord,
        input int                   c,
        input int                   n,
        input int                   cellW
    );
        logic [MAX_ROW_W-1:0] shifted;
        shifted = rowWord >> ((n - 1 - c) * cellW);
        return shifted[MAX_CELL_W-1:0] & ((MAX_CELL_W'(1) << cellW) - MAX_CELL_W'(1));
    endfunction

endpackage

// File: rtl/sudoku_grid_checker_if.sv
// Control, board-RAM read port and result bundle of the grid checker.
// The checker sits on the slave side; game control plus RAM drive the master side.
interface sudoku_grid_checker_if #(
    parameter int N      = 4,
    parameter int CELL_W = sudoku_pkg::DEFAULT_CELL_W,
    parameter int ADDR_W = $clog2(N)
);
    logic                start;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   RamAddr;
    logic [N*CELL_W-1:0] RamDat;
    logic                gameValid;
    logic                gameComplete;
    logic                errRow;
    logic                errCol;
    logic                errBox;
    logic                errRange;

    modport master (
        output start, RamDat,
        input  busy, done, RamAddr, gameValid, gameComplete,
               errRow, errCol, errBox, errRange
    );

    modport slave (
        input  start, RamDat,
        output busy, done, RamAddr, gameValid, gameComplete,
               errRow, errCol, errBox, errRange
    );
endinterface

// File: rtl/sudoku_row_decoder.sv
// Combinational row decoder: one-hot per cell (value v -> bit v-1, empty and
// out-of-range cells -> all zero), plus in-row duplicate/range/empty flags.
module sudoku_row_decoder
    import sudoku_pkg::*;
#(
    parameter int N      = 4,
    parameter int CELL_W = DEFAULT_CELL_W
) (
    input  logic [N*CELL_W-1:0]   rowWord,
    output logic [N-1:0][N-1:0]   oneHot,
    output logic                  rowDup,
    output logic                  rangeErr,
    output logic                  hasEmpty
);

    logic [N-1:0]      seen;
    logic [CELL_W-1:0] v;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        oneHot   = '0;
        rowDup   = 1'b0;
        rangeErr = 1'b0;
        hasEmpty = 1'b0;
        seen     = '0;
        v        = '0;
        for (int c = 0; c < N; c++) begin
            v = CELL_W'(cellField(MAX_ROW_W'(rowWord), c, N, CELL_W));
            if (v == '0) begin
                hasEmpty = 1'b1;
            end else if (v > CELL_W'(N)) begin
                rangeErr = 1'b1;
            end else begin
                oneHot[c] = N'(1) << (v - CELL_W'(1));
                if (|(seen & oneHot[c])) rowDup = 1'b1;
                seen = seen | oneHot[c];
            end
        end
    end

endmodule

// File: rtl/sudoku_grid_checker.sv
// Scans an N x N Sudoku grid one row per cycle from board RAM and reports
// row/column/box/range errors plus gameValid and gameComplete.
module sudoku_grid_checker
    import sudoku_pkg::*;
#(
    parameter int BOX    = 2,
    parameter int CELL_W = DEFAULT_CELL_W,
    parameter int ADDR_W = $clog2(BOX * BOX)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    sudoku_grid_checker_if.slave   bus
);

    localparam int                N        = BOX * BOX;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N - 1);

    checkStateT          state, nextState;
    logic                busy, done, accept, checking;
    logic [ADDR_W-1:0]   rowCnt, chkRow, boxSel;
    logic [N-1:0][N-1:0] colSeen, boxSeen, colNext, boxNext, oneHot;
    logic                rowDup, rangeErr, hasEmpty, colDup, boxDup;
    logic                errRow, errCol, errBox, errRange, anyEmpty;
    logic                errRowNx, errColNx, errBoxNx, errRangeNx, anyEmptyNx;
    logic                gameValid, gameComplete;

    sudoku_row_decoder #(
        .N      (N),
        .CELL_W (CELL_W)
    ) rowDecoder (
        .rowWord  (bus.RamDat),
        .oneHot   (oneHot),
        .rowDup   (rowDup),
        .rangeErr (rangeErr),
        .hasEmpty (hasEmpty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (bus.start) nextState = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (rowCnt == LAST_ROW) nextState = LAST;
            end
            LAST: begin
                busy      = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // RAM data lags the address by one cycle, so the row under check is the previous address.
    assign accept   = (state == IDLE) && bus.start;
    assign checking = ((state == SCAN) && (rowCnt != '0)) || (state == LAST);
    assign chkRow   = (state == LAST) ? rowCnt : rowCnt - ADDR_W'(1);

    always_comb begin
        colNext = colSeen;
        boxNext = boxSeen;
        colDup  = 1'b0;
        boxDup  = 1'b0;
        boxSel  = '0;
        for (int c = 0; c < N; c++) begin
            if (|(colSeen[c] & oneHot[c])) colDup = 1'b1;
            colNext[c] = colSeen[c] | oneHot[c];
            // Using the running boxNext also catches two equal cells of one box in this row.
            boxSel = ADDR_W'(boxIndex(int'(chkRow), c, BOX));
            if (|(boxNext[boxSel] & oneHot[c])) boxDup = 1'b1;
            boxNext[boxSel] = boxNext[boxSel] | oneHot[c];
        end
    end

    assign errRowNx   = errRow   | (checking & rowDup);
    assign errColNx   = errCol   | (checking & colDup);
    assign errBoxNx   = errBox   | (checking & boxDup);
    assign errRangeNx = errRange | (checking & rangeErr);
    assign anyEmptyNx = anyEmpty | (checking & hasEmpty);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rowCnt       <= '0;
            // NOTE: the seen masks are ordinary flops, so they take the async reset like the rest.
            colSeen      <= '0;
            boxSeen      <= '0;
            errRow       <= 1'b0;
            errCol       <= 1'b0;
            errBox       <= 1'b0;
            errRange     <= 1'b0;
            anyEmpty     <= 1'b0;
            gameValid    <= 1'b0;
            gameComplete <= 1'b0;
        end else if (accept) begin
            rowCnt       <= '0;
            colSeen      <= '0;
            boxSeen      <= '0;
            errRow       <= 1'b0;
            errCol       <= 1'b0;
            errBox       <= 1'b0;
            errRange     <= 1'b0;
            anyEmpty     <= 1'b0;
            gameValid    <= 1'b0;
            gameComplete <= 1'b0;
        end else begin
            if ((state == SCAN) && (rowCnt != LAST_ROW)) rowCnt <= rowCnt + ADDR_W'(1);
            if (checking) begin
                colSeen  <= colNext;
                boxSeen  <= boxNext;
                errRow   <= errRowNx;
                errCol   <= errColNx;
                errBox   <= errBoxNx;
                errRange <= errRangeNx;
                anyEmpty <= anyEmptyNx;
            end
            if (state == LAST) begin
                gameValid    <= !(errRowNx | errColNx | errBoxNx | errRangeNx);
                gameComplete <= !(errRowNx | errColNx | errBoxNx | errRangeNx | anyEmptyNx);
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.RamAddr      = rowCnt;
    assign bus.gameValid    = gameValid;
    assign bus.gameComplete = gameComplete;
    assign bus.errRow       = errRow;
    assign bus.errCol       = errCol;
    assign bus.errBox       = errBox;
    assign bus.errRange     = errRange;

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Directed bench for the 4x4 checker: a counting model of the Sudoku rules
// predicts the flags, and a compare process checks them whenever they are valid.
module tb_sudoku_grid_checker;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    sudoku_grid_checker_if #(.N(4), .CELL_W(4), .ADDR_W(2)) bus ();

    sudoku_grid_checker #(.BOX(2), .CELL_W(4), .ADDR_W(2)) dut (
        .CLK   (clk),
        .RST_N (rstN),
        .bus   (bus)
    );

    logic [15:0] mem [4];
    always @(posedge clk) bus.RamDat <= mem[bus.RamAddr];

    int vectors     = 0;
    int miscompares = 0;
    bit meaningful  = 1'b0;
    bit prevDone    = 1'b0;
    bit expRow, expCol, expBox, expRange, expValid, expComplete;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Count each legal value per row, column and box; any count above one is a duplicate.
    task automatic modelGrid();
        int cnt [5];
        int v, r, c;
        bit empty;
        expRow = 0; expCol = 0; expBox = 0; expRange = 0; empty = 0;
        r = 0; c = 0;
        for (int kind = 0; kind < 3; kind++) begin
            for (int u = 0; u < 4; u++) begin
                foreach (cnt[i]) cnt[i] = 0;
                for (int k = 0; k < 4; k++) begin
                    case (kind)
                        0:       begin r = u; c = k; end
                        1:       begin r = k; c = u; end
                        default: begin r = (u / 2) * 2 + k / 2; c = (u % 2) * 2 + k % 2; end
                    endcase
                    v = int'((mem[r] >> (4 * (3 - c))) & 16'hF);
                    if (kind == 0 && v == 0) empty = 1;
                    if (kind == 0 && v > 4) expRange = 1;
                    if (v >= 1 && v <= 4) begin
                        cnt[v]++;
                        if (cnt[v] > 1) begin
                            case (kind)
                                0:       expRow = 1;
                                1:       expCol = 1;
                                default: expBox = 1;
                            endcase
                        end
                    end
                end
            end
        end
        expValid    = !(expRow | expCol | expBox | expRange);
        expComplete = expValid && !empty;
    endtask

    always @(negedge clk) begin
        if (bus.done || (meaningful && !bus.busy)) begin
            check("model errRow",       bus.errRow,       expRow);
            check("model errCol",       bus.errCol,       expCol);
            check("model errBox",       bus.errBox,       expBox);
            check("model errRange",     bus.errRange,     expRange);
            check("model gameValid",    bus.gameValid,    expValid);
            check("model gameComplete", bus.gameComplete, expComplete);
            if (bus.done) meaningful = 1'b1;
        end
        if (bus.done) check("done single pulse", prevDone, 0);
        prevDone = bus.done;
    end

    task automatic loadGrid(input logic [15:0] r0, r1, r2, r3);
        @(posedge clk);
        #1;
        meaningful = 1'b0;
        mem[0] = r0; mem[1] = r1; mem[2] = r2; mem[3] = r3;
        modelGrid();
    endtask

    task automatic runCheck(input string tag, input logic [15:0] r0, r1, r2, r3, input bit midPulse);
        int lat;
        loadGrid(r0, r1, r2, r3);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " busy at t0"}, bus.busy, 1);
        check({tag, " addr at t0"}, bus.RamAddr, 0);
        check({tag, " flags cleared"}, {bus.errRow, bus.errCol, bus.errBox, bus.errRange,
                                         bus.gameValid, bus.gameComplete}, 0);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = midPulse && (lat == 2);
        end
        bus.start = 1'b0;
        check({tag, " latency"}, lat, 5);
        @(negedge clk);
    endtask

    task automatic expectFlags(input string tag, input bit r, c, b, g, v, cp);
        check({tag, " errRow"},       bus.errRow,       r);
        check({tag, " errCol"},       bus.errCol,       c);
        check({tag, " errBox"},       bus.errBox,       b);
        check({tag, " errRange"},     bus.errRange,     g);
        check({tag, " gameValid"},    bus.gameValid,    v);
        check({tag, " gameComplete"}, bus.gameComplete, cp);
    endtask

    task automatic expectResetOutputs(input string tag);
        check({tag, " busy"},    bus.busy,    0);
        check({tag, " done"},    bus.done,    0);
        check({tag, " RamAddr"}, bus.RamAddr, 0);
        expectFlags(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int lat, gap;
        rstN      = 1'b0;
        bus.start = 1'b0;
        foreach (mem[i]) mem[i] = 16'h0;
        #12;
        expectResetOutputs("reset");
        @(negedge clk);
        rstN = 1'b1;

        runCheck("solved", 16'h1234, 16'h3412, 16'h2143, 16'h4321, 0);
        expectFlags("solved", 0, 0, 0, 0, 1, 1);

        runCheck("coldup", 16'h1234, 16'h3412, 16'h1234, 16'h4321, 0);
        expectFlags("coldup", 0, 1, 0, 0, 0, 0);

        runCheck("rowbox", 16'h1134, 16'h3412, 16'h2143, 16'h4321, 0);
        expectFlags("rowbox", 1, 1, 1, 0, 0, 0);

        runCheck("partial", 16'h1234, 16'h3402, 16'h2143, 16'h4321, 0);
        expectFlags("partial", 0, 0, 0, 0, 1, 0);

        runCheck("range", 16'h1234, 16'h3452, 16'h2143, 16'h4321, 0);
        expectFlags("range", 0, 0, 0, 1, 0, 0);

        runCheck("resolved midpulse", 16'h1234, 16'h3412, 16'h2143, 16'h4321, 1);
        expectFlags("resolved", 0, 0, 0, 0, 1, 1);

        runCheck("boxonly", 16'h1234, 16'h2143, 16'h3412, 16'h4321, 0);
        expectFlags("boxonly", 0, 0, 1, 0, 0, 0);

        runCheck("empty", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        expectFlags("empty", 0, 0, 0, 0, 1, 0);

        // Abort a scan with reset, then prove the FSM restarts cleanly from IDLE.
        loadGrid(16'h1234, 16'h3412, 16'h2143, 16'h4321);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midscan busy", bus.busy, 1);
        rstN = 1'b0;
        #1;
        expectResetOutputs("midscan reset");
        @(negedge clk);
        rstN = 1'b1;
        runCheck("after reset", 16'h1234, 16'h3412, 16'h2143, 16'h4321, 0);
        expectFlags("after reset", 0, 0, 0, 0, 1, 1);

        // start held high: one idle cycle between scans, N+3 edges done to done.
        loadGrid(16'h1234, 16'h3412, 16'h2143, 16'h4321);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b first latency", lat, 5);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!bus.done && gap < 20);
        bus.start = 1'b0;
        check("b2b done spacing", gap, 7);
        expectFlags("b2b", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
